// File: rtl/wb_mem_ctrl_fsm.sv
// Wishbone-classic slave in front of a synchronous on-chip memory.
// Supports byte lanes, programmable read latency and write wait states, registered read data, range errors and cycle abort.
`timescale 1ns/1ps
module wb_mem_ctrl_fsm #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 1,
  parameter int WR_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam logic [3:0] RD_CNT = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_CNT = (WR_WAIT > 0) ? 4'(WR_WAIT - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                out_of_range;
  logic [MEM_AW-1:0]   word_addr;

  // Word index drops the byte-offset bits; anything above the memory depth is an error.
  generate
    if (ADDR_W - OFF_W > MEM_AW) begin : g_range
      assign word_addr    = wb_adr_i[OFF_W +: MEM_AW];
      assign out_of_range = |wb_adr_i[ADDR_W-1:OFF_W+MEM_AW];
    end else begin : g_norange
      assign word_addr    = MEM_AW'(wb_adr_i[ADDR_W-1:OFF_W]);
      assign out_of_range = 1'b0;
    end
    if (OFF_W > 0) begin : g_off
      logic unused_byte_off;
      assign unused_byte_off = ^wb_adr_i[OFF_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (out_of_range) begin
            state_d = S_ERR;
          end else begin
            addr_d  = word_addr;
            wdata_d = wb_dat_i;
            sel_d   = wb_sel_i;
            we_d    = wb_we_i;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (!we_q) begin
          state_d = S_WAIT;
          cnt_d   = RD_CNT;
        end else if (WR_WAIT == 0) begin
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WR_CNT;
        end
      end
      S_WAIT: begin
        // An abort discards the read so wb_dat_o keeps the last completed read.
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_ack_o  = (state_q == S_ACK);
  assign wb_err_o  = (state_q == S_ERR);
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS && we_q) ? sel_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_dat_o  = rdata_q;

endmodule
